// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch to
// instruction memory, holds under stall, redirects from ID, and bubbles when empty.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic [31:0] Inst,
  output logic [31:0] PC_4,
  output logic        Inst_Valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HELD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] held_r, held_s;
  logic [31:0] addr_s, inst_s, pc_4_s;
  logic        req_s, valid_s;
  logic [31:0] pc_inc_s, target_s;

  assign pc_inc_s = pc_r + 32'd4;
  assign target_s = Redirect_PC & ~32'd3;

  // State and registered-output update; every output leaves a flop.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      held_r     <= 32'd0;
      Imem_Req   <= 1'b0;
      Imem_Addr  <= RESET_PC;
      Inst       <= NOP_INST;
      PC_4       <= 32'd0;
      Inst_Valid <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      held_r     <= held_s;
      Imem_Req   <= req_s;
      Imem_Addr  <= addr_s;
      Inst       <= inst_s;
      PC_4       <= pc_4_s;
      Inst_Valid <= valid_s;
    end
  end

  // Next-state logic: Redirect beats Stall, Stall beats Ack.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    held_s  = held_r;
    req_s   = Imem_Req;
    addr_s  = Imem_Addr;
    inst_s  = Inst;
    pc_4_s  = PC_4;
    valid_s = Inst_Valid;
    case (state_r)
      IDLE: begin
        state_s = FETCH;
        req_s   = 1'b1;
        if (Redirect) begin
          pc_s    = target_s;
          addr_s  = target_s;
          inst_s  = NOP_INST;
          valid_s = 1'b0;
        end else begin
          addr_s = pc_r;
        end
      end
      FETCH: begin
        if (Redirect) begin
          pc_s    = target_s;
          inst_s  = NOP_INST;
          valid_s = 1'b0;
          if (Imem_Ack) begin
            addr_s = target_s;
          end else begin
            // Old request is still in flight; keep its address until it acks.
            state_s = DISCARD;
          end
        end else if (Stall) begin
          if (Imem_Ack) begin
            held_s  = Imem_Data;
            req_s   = 1'b0;
            state_s = HELD;
          end else begin
            state_s = FETCH;
          end
        end else if (Imem_Ack) begin
          inst_s  = Imem_Data;
          pc_4_s  = pc_inc_s;
          valid_s = 1'b1;
          pc_s    = pc_inc_s;
          addr_s  = pc_inc_s;
        end else begin
          inst_s  = NOP_INST;
          valid_s = 1'b0;
        end
      end
      HELD: begin
        if (Redirect) begin
          pc_s    = target_s;
          addr_s  = target_s;
          req_s   = 1'b1;
          inst_s  = NOP_INST;
          valid_s = 1'b0;
          state_s = FETCH;
        end else if (!Stall) begin
          inst_s  = held_r;
          pc_4_s  = pc_inc_s;
          valid_s = 1'b1;
          pc_s    = pc_inc_s;
          addr_s  = pc_inc_s;
          req_s   = 1'b1;
          state_s = FETCH;
        end else begin
          state_s = HELD;
        end
      end
      DISCARD: begin
        inst_s  = NOP_INST;
        valid_s = 1'b0;
        req_s   = 1'b1;
        if (Redirect) begin
          pc_s = target_s;
        end else if (Imem_Ack) begin
          addr_s  = pc_r;
          state_s = FETCH;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
        inst_s  = NOP_INST;
        valid_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table for the fetch corner
// cases, then randomized traffic checked against a transaction-level model.
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic [31:0] Inst;
  logic [31:0] PC_4;
  logic        Inst_Valid;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  if_fetch_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data), .Inst(Inst), .PC_4(PC_4),
    .Inst_Valid(Inst_Valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        stall, redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr, e_inst, e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, rd, input logic [31:0] rpc, input logic ak,
                     input logic [31:0] dt, input logic er, input logic [31:0] ea, ei, ep,
                     input logic ev);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rpc; v.ack = ak; v.data = dt;
    v.e_req = er; v.e_addr = ea; v.e_inst = ei; v.e_pc4 = ep; v.e_valid = ev;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic er, input logic [31:0] ea, ei, ep,
                       input logic ev);
    vectors++;
    if (Imem_Req !== er || Imem_Addr !== ea || Inst !== ei || PC_4 !== ep || Inst_Valid !== ev) begin
      miscompares++;
      $display("FAIL %s: got req=%0b addr=%h inst=%h pc4=%h valid=%0b, want req=%0b addr=%h inst=%h pc4=%h valid=%0b",
               name, Imem_Req, Imem_Addr, Inst, PC_4, Inst_Valid, er, ea, ei, ep, ev);
    end
  endtask

  // Reference model: a PC, one outstanding request, an optional parked word,
  // and a flag saying the in-flight request's data is to be thrown away.
  logic        m_started, m_parked, m_dropping;
  logic [31:0] m_pc, m_req_addr, m_park, m_inst, m_pc4;
  logic        m_valid;

  task automatic model_reset();
    m_started = 1'b0; m_parked = 1'b0; m_dropping = 1'b0;
    m_pc = 32'd0; m_req_addr = 32'd0; m_park = 32'd0;
    m_inst = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic st, rd, input logic [31:0] rpc, input logic ak,
                            input logic [31:0] dt);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    if (!m_started) begin
      m_started = 1'b1;
      if (rd) begin m_pc = tgt; m_inst = NOP; m_valid = 1'b0; end
      m_req_addr = m_pc;
    end else if (m_parked) begin
      if (rd) begin
        m_parked = 1'b0; m_pc = tgt; m_req_addr = tgt; m_inst = NOP; m_valid = 1'b0;
      end else if (!st) begin
        m_parked = 1'b0; m_inst = m_park; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_req_addr = m_pc;
      end
    end else if (m_dropping) begin
      m_inst = NOP; m_valid = 1'b0;
      if (rd) m_pc = tgt;
      else if (ak) begin m_dropping = 1'b0; m_req_addr = m_pc; end
    end else begin
      if (rd) begin
        m_pc = tgt; m_inst = NOP; m_valid = 1'b0;
        if (ak) m_req_addr = tgt; else m_dropping = 1'b1;
      end else if (st) begin
        if (ak) begin m_park = dt; m_parked = 1'b1; end
      end else if (ak) begin
        m_inst = dt; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_req_addr = m_pc;
      end else begin
        m_inst = NOP; m_valid = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic st, rd, input logic [31:0] rpc, input logic ak,
                       input logic [31:0] dt);
    Stall = st; Redirect = rd; Redirect_PC = rpc; Imem_Ack = ak; Imem_Data = dt;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 32'd0;
    Imem_Ack = 1'b0; Imem_Data = 32'd0;

    //     st rd rpc            ak data            req addr           inst           pc4            v
    add(0, 0, 32'h0,         1, 32'hA5A5_0000, 1, 32'h0000_0000, NOP,           32'h0000_0000, 0);
    add(0, 0, 32'h0,         1, 32'hA5A5_0000, 1, 32'h0000_0004, 32'hA5A5_0000, 32'h0000_0004, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0004, NOP,           32'h0000_0004, 0);
    add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0004, NOP,           32'h0000_0004, 0);
    add(0, 0, 32'h0,         1, 32'hA5A5_0004, 1, 32'h0000_0008, 32'hA5A5_0004, 32'h0000_0008, 1);
    add(1, 0, 32'h0,         1, 32'hAABB_CCDD, 0, 32'h0000_0008, 32'hA5A5_0004, 32'h0000_0008, 1);
    add(1, 0, 32'h0,         1, 32'h1234_5678, 0, 32'h0000_0008, 32'hA5A5_0004, 32'h0000_0008, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_000C, 32'hAABB_CCDD, 32'h0000_000C, 1);
    add(0, 0, 32'h0,         1, 32'h1111_1111, 1, 32'h0000_0010, 32'h1111_1111, 32'h0000_0010, 1);
    add(0, 1, 32'h100,       0, 32'h0,         1, 32'h0000_0010, NOP,           32'h0000_0010, 0);
    add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010, NOP,           32'h0000_0010, 0);
    add(0, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h0000_0100, NOP,           32'h0000_0010, 0);
    add(0, 0, 32'h0,         1, 32'h2222_2222, 1, 32'h0000_0104, 32'h2222_2222, 32'h0000_0104, 1);
    add(1, 1, 32'h203,       0, 32'h0,         1, 32'h0000_0104, NOP,           32'h0000_0104, 0);
    add(0, 0, 32'h0,         1, 32'hBAD0_BAD0, 1, 32'h0000_0200, NOP,           32'h0000_0104, 0);
    add(0, 1, 32'hFFFF_FFFF, 1, 32'hBAD1_BAD1, 1, 32'hFFFF_FFFC, NOP,           32'h0000_0104, 0);
    add(0, 0, 32'h0,         1, 32'h3333_3333, 1, 32'h0000_0000, 32'h3333_3333, 32'h0000_0000, 1);
    add(1, 0, 32'h0,         1, 32'h4444_4444, 0, 32'h0000_0000, 32'h3333_3333, 32'h0000_0000, 1);
    add(1, 1, 32'h40,        0, 32'h0,         1, 32'h0000_0040, NOP,           32'h0000_0000, 0);
    add(0, 0, 32'h0,         1, 32'h5555_5555, 1, 32'h0000_0044, 32'h5555_5555, 32'h0000_0044, 1);
    add(0, 1, 32'h80,        0, 32'h0,         1, 32'h0000_0044, NOP,           32'h0000_0044, 0);
    add(0, 1, 32'h92,        0, 32'h0,         1, 32'h0000_0044, NOP,           32'h0000_0044, 0);
    add(0, 0, 32'h0,         1, 32'h6666_6666, 1, 32'h0000_0090, NOP,           32'h0000_0044, 0);
    add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0090, NOP,           32'h0000_0044, 0);

    #12;
    check("reset_initial", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].ack, tbl[i].data);
      check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_inst,
            tbl[i].e_pc4, tbl[i].e_valid);
    end

    // Asynchronous reset in the middle of an outstanding fetch, no clock edge.
    #2;
    Rst_n = 1'b0;
    #1;
    check("reset_midwait", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      logic        st, rd, ak;
      logic [31:0] rpc, dt;
      st  = ($urandom % 10) < 3;
      rd  = ($urandom % 12) == 0;
      ak  = ($urandom % 2) == 1;
      dt  = $urandom;
      rpc = (($urandom % 8) == 0) ? (32'hFFFF_FFFC | ($urandom % 4)) : $urandom;
      if (($urandom % 400) == 0) begin
        #2;
        Rst_n = 1'b0;
        #1;
        model_reset();
        check($sformatf("rnd_reset%0d", n), 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
      end
      model_step(st, rd, rpc, ak, dt);
      drive(st, rd, rpc, ak, dt);
      check($sformatf("rnd%0d", n), m_started && !m_parked, m_req_addr, m_inst, m_pc4, m_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
